// File: rtl/python_spi_responder_if.sv
// Pin-level bundle for the camera-imager SPI responder: raw SPI pins plus
// the fabric-side write/error report.
interface python_spi_responder_if #(
  parameter int AW = 9,
  parameter int DW = 16
);
  logic          cs;
  logic          sck;
  logic          mosi;
  logic          miso;
  logic          wr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          err;
  logic          busy;

  modport master (
    output cs, sck, mosi,
    input  miso, wr, wr_addr, wr_data, err, busy
  );

  modport slave (
    input  cs, sck, mosi,
    output miso, wr, wr_addr, wr_data, err, busy
  );
endinterface

// File: rtl/python_spi_responder.sv
// SPI slave (CPOL=0, CPHA=0) standing in for the camera imager register port.
// Oversamples raw pins in the c domain and serves a local AW x DW register bank.
module python_spi_responder #(
  parameter int            AW      = 9,
  parameter int            DW      = 16,
  parameter logic [DW-1:0] CHIP_ID = 16'h50D0
) (
  input  logic                    c,
  input  logic                    rst,
  python_spi_responder_if.slave   bus
);

  localparam int FL = AW + 1 + DW;

  typedef enum logic [1:0] {WAIT_CSH, IDLE, SHIFT, OVER} state_e;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [FL-1:0]   sr_q, sr_d;
  logic            rd_q, rd_d;
  logic            miso_q, miso_d;
  logic            wr_q, wr_d;
  logic            err_q, err_d;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;
  logic            we;
  logic [DW-1:0]   ram_q;
  logic [DW-1:0]   rdat_q;
  logic [DW-1:0]   mem [2**AW];

  // [0],[1] synchronize, [2] is the previous sample for edge detection
  logic [2:0] cs_sq, sck_sq, mosi_sq;

  logic cs_rise, cs_fall, sck_rise, sck_fall;

  // Bit presented on miso for the fall that follows rise number n.
  function automatic logic pick_bit(input logic [DW-1:0] w, input logic [4:0] n);
    pick_bit = 1'b0;
    for (int i = 0; i < DW; i++)
      if (5'(AW + 1 + i) == n) pick_bit = w[DW-1-i];
  endfunction

  always_ff @(posedge c) begin
    cs_sq   <= {cs_sq[1:0],   bus.cs};
    sck_sq  <= {sck_sq[1:0],  bus.sck};
    mosi_sq <= {mosi_sq[1:0], bus.mosi};
  end

  assign cs_rise  =  cs_sq[1]  & ~cs_sq[2];
  assign cs_fall  = ~cs_sq[1]  &  cs_sq[2];
  assign sck_rise =  sck_sq[1] & ~sck_sq[2];
  assign sck_fall = ~sck_sq[1] &  sck_sq[2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    rd_d    = rd_q;
    miso_d  = miso_q;
    wr_d    = 1'b0;
    err_d   = 1'b0;
    we      = 1'b0;
    case (state_q)
      WAIT_CSH: begin
        miso_d = 1'b0;
        if (cs_sq[1]) state_d = IDLE;
      end
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          sr_d    = '0;
          cnt_d   = '0;
          rd_d    = 1'b0;
          state_d = SHIFT;
        end
      end
      default: begin
        // cs rise has priority over any sck edge seen in the same cycle
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
          if (cnt_q == 5'(FL)) begin
            if (sr_q[DW] && (sr_q[FL-1:DW+1] != '0)) begin
              we   = 1'b1;
              wr_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          if (sck_rise) begin
            if (state_q == SHIFT) begin
              sr_d  = {sr_q[FL-2:0], mosi_sq[2]};
              cnt_d = cnt_q + 5'd1;
              if (cnt_q == 5'(FL - 1)) state_d = OVER;
            end else if (cnt_q != 5'(FL + 1)) begin
              cnt_d = cnt_q + 5'd1;
            end
          end
          if (sck_fall) miso_d = rd_q ? pick_bit(rdat_q, cnt_q) : 1'b0;
          if (state_q == SHIFT && cnt_q == 5'(AW + 1)) rd_d = ~sr_q[0];
        end
      end
    endcase
  end

  always_ff @(posedge c) begin
    if (rst) begin
      state_q   <= WAIT_CSH;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      miso_q    <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      miso_q  <= miso_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      if (we) begin
        wr_addr_q <= sr_q[FL-1:DW+1];
        wr_data_q <= sr_q[DW-1:0];
      end
    end
  end

  // Register bank and read-word latch; the address field is stable from the
  // 10th rise until the 11th, which leaves time for the two-cycle read.
  always_ff @(posedge c) begin
    sr_q <= sr_d;
    if (we) mem[sr_q[FL-1:DW+1]] <= sr_q[DW-1:0];
    ram_q <= mem[sr_q[AW:1]];
    if (state_q == SHIFT && cnt_q == 5'(AW + 1))
      rdat_q <= (sr_q[AW:1] == '0) ? CHIP_ID : ram_q;
  end

  assign bus.miso    = miso_q;
  assign bus.wr      = wr_q;
  assign bus.err     = err_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = (state_q == SHIFT) || (state_q == OVER);

endmodule

// File: tb/tb_python_spi_responder.sv
// Directed and randomized SPI frames against a register-bank reference model.
module tb_python_spi_responder;

  localparam int H = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0, cs_cyc = 0, wr_cyc = 0;
  int   wr_cnt = 0, err_cnt = 0;
  logic cs_prev = 1'b1;

  logic [15:0] mdl [logic [8:0]];
  logic [8:0]  exp_wa = '0;
  logic [15:0] exp_wd = '0;
  logic [8:0]  pool [6] = '{9'h000, 9'h0C0, 9'h010, 9'h1FF, 9'h055, 9'h101};

  python_spi_responder_if #(.AW(9), .DW(16)) bus ();

  python_spi_responder #(.AW(9), .DW(16), .CHIP_ID(16'h50D0)) dut (
    .c   (clk),
    .rst (rst),
    .bus (bus)
  );

  always #4 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (bus.cs && !cs_prev) cs_cyc = cyc;
    cs_prev = bus.cs;
    if (bus.wr) begin
      wr_cnt++;
      wr_cyc = cyc;
    end
    if (bus.err) err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One master frame plus all checks the reference model implies for it.
  task automatic xact(input string tag, input logic [8:0] a, input logic rw,
                      input logic [15:0] d, input int nbits, input int rst_after,
                      input bit coincide);
    logic [25:0] w;
    logic [31:0] rx;
    logic        busy_mid;
    int          wr0, err0, eff;
    bit          good;
    w = {a, rw, d};
    rx = '0;
    busy_mid = 1'b0;
    wr0 = wr_cnt;
    err0 = err_cnt;
    bus.cs = 1'b0;
    tick(H);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = (i < 26) ? w[25-i] : 1'b0;
      tick(H);
      bus.sck = 1'b1;
      rx = {rx[30:0], bus.miso};
      if (coincide && i == nbits - 1) bus.cs = 1'b1;
      tick(H);
      if (i == 5) busy_mid = bus.busy;
      bus.sck = 1'b0;
      if (rst_after == i + 1) begin
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        exp_wa = '0;
        exp_wd = '0;
      end
    end
    tick(H);
    bus.cs = 1'b1;
    tick(16);

    eff  = coincide ? nbits - 1 : nbits;
    good = (eff == 26) && (rst_after == 0);
    if (rst_after == 0) check({tag, ".busy_mid"}, 32'(busy_mid), 32'd1);
    check({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, ".err_cnt"}, 32'(err_cnt - err0),
          32'((rst_after == 0 && eff != 26) ? 1 : 0));
    if (good && rw && a != 9'h000) begin
      mdl[a] = d;
      exp_wa = a;
      exp_wd = d;
      check({tag, ".wr_cnt"}, 32'(wr_cnt - wr0), 32'd1);
      check({tag, ".wr_lat_ok"}, 32'((wr_cyc - cs_cyc) >= 2 && (wr_cyc - cs_cyc) <= 4), 32'd1);
    end else begin
      check({tag, ".wr_cnt"}, 32'(wr_cnt - wr0), 32'd0);
    end
    check({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'(exp_wa));
    check({tag, ".wr_data"}, 32'(bus.wr_data), 32'(exp_wd));
    if (rw) check({tag, ".miso_quiet"}, rx, 32'd0);
    if (good && !rw) begin
      check({tag, ".rd_hdr_zero"}, 32'(rx[25:16]), 32'd0);
      check({tag, ".rd_data"}, 32'(rx[15:0]), 32'((a == 9'h000) ? 16'h50D0 : mdl[a]));
    end
    check({tag, ".miso_idle"}, 32'(bus.miso), 32'd0);
  endtask

  initial begin
    logic [8:0]  ra;
    logic        rrw;
    logic [15:0] rd;
    int          rn, sel;
    bus.cs = 1'b1;
    bus.sck = 1'b0;
    bus.mosi = 1'b0;
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(3);
    check("rst.miso", 32'(bus.miso), 32'd0);
    check("rst.wr", 32'(bus.wr), 32'd0);
    check("rst.err", 32'(bus.err), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst.wr_data", 32'(bus.wr_data), 32'd0);

    xact("wr_c0", 9'h0C0, 1'b1, 16'hA5C3, 26, 0, 1'b0);
    xact("wr_10", 9'h010, 1'b1, 16'h1234, 26, 0, 1'b0);
    xact("rd_10", 9'h010, 1'b0, 16'h0000, 26, 0, 1'b0);
    xact("rd_id", 9'h000, 1'b0, 16'h0000, 26, 0, 1'b0);
    xact("wr_id", 9'h000, 1'b1, 16'hFFFF, 26, 0, 1'b0);
    xact("rd_id2", 9'h000, 1'b0, 16'h0000, 26, 0, 1'b0);
    xact("short", 9'h0C0, 1'b1, 16'hDEAD, 20, 0, 1'b0);
    xact("long", 9'h0C0, 1'b1, 16'hBEEF, 30, 0, 1'b0);
    xact("rd_c0", 9'h0C0, 1'b0, 16'h0000, 26, 0, 1'b0);
    xact("rstmid", 9'h0C0, 1'b1, 16'h7777, 26, 12, 1'b0);
    xact("wr_post", 9'h055, 1'b1, 16'h0F0F, 26, 0, 1'b0);
    xact("rd_c0b", 9'h0C0, 1'b0, 16'h0000, 26, 0, 1'b0);
    xact("coinc", 9'h010, 1'b1, 16'h9999, 26, 0, 1'b1);
    xact("rd_10b", 9'h010, 1'b0, 16'h0000, 26, 0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      ra  = pool[$urandom_range(0, 5)];
      rrw = 1'($urandom_range(0, 1));
      rd  = 16'($urandom);
      if (!rrw && ra != 9'h000 && !mdl.exists(ra)) rrw = 1'b1;
      sel = int'($urandom_range(0, 9));
      rn  = (sel == 0) ? 20 : (sel == 1) ? 27 : (sel == 2) ? 30 : 26;
      xact($sformatf("rnd%0d", k), ra, rrw, rd, rn, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
